slave_in_port: RTL

Serial-bus receive stage on the slave side. Sits directly downstream of the master output port: it takes the single-bit address, burst-size and write-data lines, plus the read/write strobes, and deserializes them into parallel transactions for the slave's memory. Every write word is presented as a one-cycle pulse. Every read is presented as a single request that the slave output path services.

---
 rtl/slave_in_port.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/slave_in_port.sv
// slave_in_port: serial-bus receive stage on the slave side.
// Deserializes header and write data into parallel read/write transactions.
module slave_in_port #(
    parameter int SLAVE_ADDR_SIZE = 12,
    parameter int BURST_SIZE      = 12,
    parameter int WORD_SIZE       = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       addr_bus,
    input  logic                       burst_size_bus,
    input  logic                       w_data_bus,
    input  logic                       read_en,
    input  logic                       write_en,
    input  logic                       m_valid,
    input  logic                       slave_sel,
    output logic                       s_ready,
    output logic [SLAVE_ADDR_SIZE-1:0] s_addr,
    output logic [BURST_SIZE-1:0]      s_burst,
    output logic                       s_rd_req,
    output logic                       s_wr_valid,
    output logic [SLAVE_ADDR_SIZE-1:0] s_wr_addr,
    output logic [WORD_SIZE-1:0]       s_wdata,
    output logic                       s_done
);

    localparam int HDR_LEN = (SLAVE_ADDR_SIZE > BURST_SIZE) ?
                             SLAVE_ADDR_SIZE : BURST_SIZE;
    localparam int HCW = $clog2(HDR_LEN + 1);
    localparam int BCW = $clog2(WORD_SIZE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic                       is_wr;
    logic [HCW-1:0]             hdr_cnt;
    logic [BCW-1:0]             bit_cnt;
    logic [BURST_SIZE-1:0]      word_cnt;
    logic [SLAVE_ADDR_SIZE-1:0] addr_sh;
    logic [BURST_SIZE-1:0]      burst_sh;
    logic [WORD_SIZE-2:0]       data_sh;

    logic                       beat;
    logic                       start;
    logic                       hdr_last;
    logic                       bit_last;
    logic                       word_last;
    logic                       hdr_fire;
    logic                       word_fire;
    logic [BURST_SIZE-1:0]      n_last;
    logic [SLAVE_ADDR_SIZE-1:0] addr_cat;
    logic [BURST_SIZE-1:0]      burst_cat;
    logic [WORD_SIZE-1:0]       word_cat;

    logic rd_req_nxt;
    logic wr_valid_nxt;
    logic done_nxt;
    logic ld_hdr;
    logic ld_word;

    assign beat      = m_valid & slave_sel;
    assign start     = beat & (read_en ^ write_en);
    assign hdr_last  = (hdr_cnt == HCW'(HDR_LEN - 1));
    assign bit_last  = (bit_cnt == BCW'(WORD_SIZE - 1));
    // A zero burst length still moves one word
    assign n_last    = (s_burst == '0) ? '0 : s_burst - BURST_SIZE'(1);
    assign word_last = (word_cnt == n_last);
    assign hdr_fire  = (state == HDR) && beat && hdr_last;
    assign word_fire = (state == DATA) && beat && bit_last;
    assign word_cat  = {w_data_bus, data_sh};

    always_comb begin
        addr_cat = addr_sh;
        for (int i = 0; i < SLAVE_ADDR_SIZE; i++) begin
            if (hdr_cnt == HCW'(i)) addr_cat[i] = addr_bus;
        end
    end

    always_comb begin
        burst_cat = burst_sh;
        for (int i = 0; i < BURST_SIZE; i++) begin
            if (hdr_cnt == HCW'(i)) burst_cat[i] = burst_size_bus;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = HDR;
            end
            HDR: begin
                if (!slave_sel)
                    state_nxt = IDLE;
                else if (m_valid && hdr_last)
                    state_nxt = is_wr ? DATA : IDLE;
            end
            DATA: begin
                if (!slave_sel)
                    state_nxt = IDLE;
                else if (m_valid && bit_last && word_last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_req_nxt   = 1'b0;
        wr_valid_nxt = 1'b0;
        done_nxt     = 1'b0;
        ld_hdr       = 1'b0;
        ld_word      = 1'b0;
        unique case (1'b1)
            hdr_fire: begin
                ld_hdr     = 1'b1;
                rd_req_nxt = !is_wr;
                done_nxt   = !is_wr;
            end
            word_fire: begin
                ld_word      = 1'b1;
                wr_valid_nxt = 1'b1;
                done_nxt     = word_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_wr    <= 1'b0;
            hdr_cnt  <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            addr_sh  <= '0;
            burst_sh <= '0;
            data_sh  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        is_wr    <= write_en;
                        addr_sh  <= addr_cat;
                        burst_sh <= burst_cat;
                        hdr_cnt  <= HCW'(1);
                    end
                end
                HDR: begin
                    if (!slave_sel) begin
                        hdr_cnt <= '0;
                    end else if (m_valid) begin
                        addr_sh  <= addr_cat;
                        burst_sh <= burst_cat;
                        if (hdr_last) begin
                            hdr_cnt  <= '0;
                            bit_cnt  <= '0;
                            word_cnt <= '0;
                        end else begin
                            hdr_cnt <= hdr_cnt + HCW'(1);
                        end
                    end
                end
                DATA: begin
                    if (!slave_sel) begin
                        bit_cnt  <= '0;
                        word_cnt <= '0;
                    end else if (m_valid) begin
                        data_sh <= word_cat[WORD_SIZE-1:1];
                        if (bit_last) begin
                            bit_cnt  <= '0;
                            word_cnt <= word_last ? '0 :
                                        word_cnt + BURST_SIZE'(1);
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                end
                default: begin
                    hdr_cnt  <= '0;
                    bit_cnt  <= '0;
                    word_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready    <= 1'b1;
            s_addr     <= '0;
            s_burst    <= '0;
            s_rd_req   <= 1'b0;
            s_wr_valid <= 1'b0;
            s_wr_addr  <= '0;
            s_wdata    <= '0;
            s_done     <= 1'b0;
        end else begin
            s_ready    <= (state_nxt == IDLE);
            s_rd_req   <= rd_req_nxt;
            s_wr_valid <= wr_valid_nxt;
            s_done     <= done_nxt;
            if (ld_hdr) begin
                s_addr  <= addr_cat;
                s_burst <= burst_cat;
            end
            if (ld_word) begin
                s_wdata   <= word_cat;
                s_wr_addr <= s_addr + SLAVE_ADDR_SIZE'(word_cnt);
            end
        end
    end

endmodule
